// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding and
// the counter-width helper.
package reset_seq_pkg;

    localparam logic [1:0] HOLD    = 2'd0;
    localparam logic [1:0] RELEASE = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD    = HOLD,
        ST_RELEASE = RELEASE,
        ST_RUN     = RUN
    } seq_state_e;

    // Wide enough to hold the larger of the two programmable delays.
    function automatic int cnt_width(input int assert_cycles, input int stage_delay);
        int m;
        m = (assert_cycles > stage_delay) ? assert_cycles : stage_delay;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset bridge: asserts asynchronously with rst_n, deasserts after STAGES
// rising edges of clk.
module reset_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sync_rst_n_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], {WIDTH{1'b1}}};
        end
    end

    assign sync_rst_n_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: synchronised board-reset release followed by
// one-at-a-time domain releases, plus a req/ack software re-reset.
//
// state   | meaning
// HOLD    | all domains in reset, counting ASSERT_CYCLES synced edges
// RELEASE | releasing domain idx after STAGE_DELAY edges (stalls on hold)
// RUN     | all domains released, accepting software re-reset requests
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int ASSERT_CYCLES = 4,
    parameter int STAGE_DELAY   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_DOMAINS-1:0] domain_hold,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   seq_done,
    output logic                   busy
);

    localparam int CNT_W = cnt_width(ASSERT_CYCLES, STAGE_DELAY);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] ASSERT_CNT = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    logic                   rst_sync;
    seq_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] domain_rst_n_q;
    logic                   seq_done_q;
    logic                   busy_q;
    logic                   ack_q;
    logic                   sw_seq_q;

    reset_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_rst_n_o (rst_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            idx_q          <= '0;
            domain_rst_n_q <= '0;
            seq_done_q     <= 1'b0;
            busy_q         <= 1'b1;
            ack_q          <= 1'b0;
            sw_seq_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (rst_sync) begin
                        if (cnt_q == ASSERT_CNT) begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    // Counter parks at its last value while the current domain is held.
                    if (cnt_q == STAGE_LAST) begin
                        if (!domain_hold[idx_q]) begin
                            domain_rst_n_q[idx_q] <= 1'b1;
                            cnt_q                 <= '0;
                            if (idx_q == LAST_IDX) begin
                                state_q    <= ST_RUN;
                                seq_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                                ack_q      <= sw_seq_q;
                                sw_seq_q   <= 1'b0;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // The accepting edge is the first counted HOLD edge.
                    if (sw_rst_req && !ack_q) begin
                        state_q        <= ST_HOLD;
                        cnt_q          <= CNT_W'(1);
                        domain_rst_n_q <= '0;
                        seq_done_q     <= 1'b0;
                        busy_q         <= 1'b1;
                        sw_seq_q       <= 1'b1;
                    end else if (!sw_rst_req) begin
                        ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign domain_rst_n = domain_rst_n_q;
    assign seq_done     = seq_done_q;
    assign busy         = busy_q;
    assign sw_rst_ack   = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters; expected edge
// numbers are counted from T0, the first rising edge with rst_n high.
module tb_reset_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] domain_hold = '0;
    logic         sw_rst_req = 1'b0;
    logic         sw_rst_ack;
    logic [N-1:0] domain_rst_n;
    logic         seq_done;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int now   = 0;

    reset_sequencer #(
        .NUM_DOMAINS   (4),
        .SYNC_STAGES   (2),
        .ASSERT_CYCLES (4),
        .STAGE_DELAY   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .domain_hold  (domain_hold),
        .sw_rst_req   (sw_rst_req),
        .sw_rst_ack   (sw_rst_ack),
        .domain_rst_n (domain_rst_n),
        .seq_done     (seq_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after edge number e (relative to T0).
    task automatic goto(input int e);
        while (now < e) begin
            @(posedge clk);
            #1;
            now++;
        end
    endtask

    // Five reset cycles, then release; the next edge is T0.
    task automatic por();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        now   = -1;
    endtask

    task automatic test_reset();
        sw_rst_req  = 1'b0;
        domain_hold = '0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({domain_rst_n, seq_done, busy, sw_rst_ack} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_async: got dom=%b done=%b busy=%b ack=%b want dom=0000 done=0 busy=1 ack=0",
                     domain_rst_n, seq_done, busy, sw_rst_ack);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({domain_rst_n, seq_done, busy, sw_rst_ack} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_clocked: got dom=%b done=%b busy=%b ack=%b want dom=0000 done=0 busy=1 ack=0",
                     domain_rst_n, seq_done, busy, sw_rst_ack);
        end
    endtask

    task automatic test_power_on();
        int         e[8] = '{13, 14, 21, 22, 29, 30, 37, 38};
        logic [3:0] d[8] = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hf};
        logic [2:0] expf;
        por();
        for (int i = 0; i < 8; i++) begin
            goto(e[i]);
            expf = {d[i] == 4'hf, d[i] != 4'hf, 1'b0};
            total++;
            if (domain_rst_n !== d[i]) begin
                bad++;
                $display("FAIL por_dom@%0d: got %b want %b", e[i], domain_rst_n, d[i]);
            end
            total++;
            if ({seq_done, busy, sw_rst_ack} !== expf) begin
                bad++;
                $display("FAIL por_flags@%0d: got done/busy/ack=%b want %b",
                         e[i], {seq_done, busy, sw_rst_ack}, expf);
            end
        end
        goto(45);
        total++;
        if ({domain_rst_n, seq_done, busy, sw_rst_ack} !== {4'hf, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL por_idle: got dom=%b done=%b busy=%b ack=%b want 1111 1 0 0",
                     domain_rst_n, seq_done, busy, sw_rst_ack);
        end
    endtask

    task automatic test_hold();
        int         e[8] = '{14, 22, 40, 41, 48, 49, 56, 57};
        logic [3:0] d[8] = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hf};
        domain_hold = 4'b0010;
        por();
        for (int i = 0; i < 8; i++) begin
            goto(e[i]);
            total++;
            if (domain_rst_n !== d[i] || seq_done !== (d[i] == 4'hf)) begin
                bad++;
                $display("FAIL hold_dom@%0d: got dom=%b done=%b want dom=%b done=%b",
                         e[i], domain_rst_n, seq_done, d[i], d[i] == 4'hf);
            end
            if (e[i] == 40) domain_hold = 4'b0000;
        end
        domain_hold = 4'b1111;
        goto(62);
        total++;
        if (domain_rst_n !== 4'hf || seq_done !== 1'b1) begin
            bad++;
            $display("FAIL hold_after_release: got dom=%b done=%b want 1111 1", domain_rst_n, seq_done);
        end
        domain_hold = 4'b0000;
    endtask

    task automatic test_sw_rereset();
        int         off[5] = '{1, 12, 13, 36, 37};
        logic [3:0] d[5]   = '{4'h0, 4'h0, 4'h1, 4'h7, 4'hf};
        logic [2:0] expf;
        int         e;
        por();
        goto(40);
        e = now;
        sw_rst_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            goto(e + off[i]);
            expf = {d[i] == 4'hf, d[i] != 4'hf, d[i] == 4'hf};
            total++;
            if (domain_rst_n !== d[i] || {seq_done, busy, sw_rst_ack} !== expf) begin
                bad++;
                $display("FAIL sw_seq@E+%0d: got dom=%b done/busy/ack=%b want dom=%b flags=%b",
                         off[i], domain_rst_n, {seq_done, busy, sw_rst_ack}, d[i], expf);
            end
        end
        goto(e + 44);
        total++;
        if (domain_rst_n !== 4'hf || sw_rst_ack !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL sw_req_held: got dom=%b ack=%b busy=%b want 1111 1 0", domain_rst_n, sw_rst_ack, busy);
        end
        sw_rst_req = 1'b0;
        goto(e + 45);
        total++;
        if (sw_rst_ack !== 1'b0 || domain_rst_n !== 4'hf) begin
            bad++;
            $display("FAIL sw_ack_drop: got ack=%b dom=%b want 0 1111", sw_rst_ack, domain_rst_n);
        end
        sw_rst_req = 1'b1;
        goto(e + 46);
        total++;
        if (domain_rst_n !== 4'h0 || busy !== 1'b1 || sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL sw_second_req: got dom=%b busy=%b ack=%b want 0000 1 0", domain_rst_n, busy, sw_rst_ack);
        end
        goto(e + 82);
        total++;
        if (domain_rst_n !== 4'hf || seq_done !== 1'b1 || sw_rst_ack !== 1'b1) begin
            bad++;
            $display("FAIL sw_second_done: got dom=%b done=%b ack=%b want 1111 1 1", domain_rst_n, seq_done, sw_rst_ack);
        end
        sw_rst_req = 1'b0;
        goto(e + 83);
    endtask

    task automatic test_req_busy();
        por();
        goto(20);
        sw_rst_req = 1'b1;
        goto(38);
        total++;
        if (domain_rst_n !== 4'hf || seq_done !== 1'b1 || sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL busy_req_done@38: got dom=%b done=%b ack=%b want 1111 1 0", domain_rst_n, seq_done, sw_rst_ack);
        end
        goto(39);
        total++;
        if (domain_rst_n !== 4'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_req_rereset@39: got dom=%b busy=%b want 0000 1", domain_rst_n, busy);
        end
        goto(50);
        total++;
        if (domain_rst_n !== 4'h0) begin
            bad++;
            $display("FAIL busy_req_dom0@50: got %b want 0000", domain_rst_n);
        end
        goto(51);
        total++;
        if (domain_rst_n !== 4'h1) begin
            bad++;
            $display("FAIL busy_req_dom0@51: got %b want 0001", domain_rst_n);
        end
        goto(74);
        total++;
        if (seq_done !== 1'b0 || sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL busy_req_pre_done@74: got done=%b ack=%b want 0 0", seq_done, sw_rst_ack);
        end
        goto(75);
        total++;
        if (domain_rst_n !== 4'hf || seq_done !== 1'b1 || sw_rst_ack !== 1'b1) begin
            bad++;
            $display("FAIL busy_req_done@75: got dom=%b done=%b ack=%b want 1111 1 1", domain_rst_n, seq_done, sw_rst_ack);
        end
        sw_rst_req = 1'b0;
        goto(76);
        total++;
        if (sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL busy_req_ack_drop@76: got %b want 0", sw_rst_ack);
        end
    endtask

    task automatic test_abort();
        por();
        goto(25);
        total++;
        if (domain_rst_n !== 4'h3) begin
            bad++;
            $display("FAIL abort_pre@25: got %b want 0011", domain_rst_n);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({domain_rst_n, seq_done, busy} !== {4'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL abort_async: got dom=%b done=%b busy=%b want 0000 0 1", domain_rst_n, seq_done, busy);
        end
        por();
        goto(13);
        total++;
        if (domain_rst_n !== 4'h0) begin
            bad++;
            $display("FAIL abort_restart@13: got %b want 0000", domain_rst_n);
        end
        goto(14);
        total++;
        if (domain_rst_n !== 4'h1) begin
            bad++;
            $display("FAIL abort_restart@14: got %b want 0001", domain_rst_n);
        end
        goto(38);
        total++;
        if (domain_rst_n !== 4'hf || seq_done !== 1'b1 || sw_rst_ack !== 1'b0) begin
            bad++;
            $display("FAIL abort_restart@38: got dom=%b done=%b ack=%b want 1111 1 0", domain_rst_n, seq_done, sw_rst_ack);
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_hold();
        test_sw_rereset();
        test_req_busy();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
